// File: rtl/pcm56_pkg.sv
// Shared constants, lane source selects and transfer FSM states for the PCM56 frame scheduler.
package pcm56_pkg;
    localparam int unsigned BIT_DEF  = 24;
    localparam int unsigned WORD_DEF = 16;
    localparam int unsigned NCH_DEF  = 4;

    localparam logic [1:0] SEL_LEFT  = 2'd0;
    localparam logic [1:0] SEL_RIGHT = 2'd1;
    localparam logic [1:0] SEL_MONO  = 2'd2;
    localparam logic [1:0] SEL_ZERO  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        LATCH = 2'd3
    } state_e;
endpackage

// File: rtl/pcm56_word_fmt.sv
// One DAC lane word: source select / mono mix, round-half-up to WORD bits, saturate, mute.
module pcm56_word_fmt
    import pcm56_pkg::*;
#(
    parameter int unsigned BIT  = BIT_DEF,
    parameter int unsigned WORD = WORD_DEF
) (
    input  logic [BIT-1:0]  l_i,
    input  logic [BIT-1:0]  r_i,
    input  logic [1:0]      sel_i,
    input  logic            mute_i,
    output logic [WORD-1:0] word_o
);
    localparam int unsigned SW = BIT + 1;
    localparam int unsigned SH = BIT - WORD;
    localparam logic signed [SW-1:0] RND  = SW'(1 << (SH - 1));
    localparam logic signed [SW-1:0] MAXV = SW'((1 << (WORD - 1)) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic signed [SW-1:0] l_x, r_x, mono, src, rnd, shr, sat;

    always_comb begin
        l_x  = {l_i[BIT-1], l_i};
        r_x  = {r_i[BIT-1], r_i};
        mono = (l_x + r_x) >>> 1;
        case (sel_i)
            SEL_LEFT:  src = l_x;
            SEL_RIGHT: src = r_x;
            SEL_MONO:  src = mono;
            default:   src = '0;
        endcase
        rnd = src + RND;
        shr = rnd >>> SH;
        if (shr > MAXV)      sat = MAXV;
        else if (shr < MINV) sat = MINV;
        else                 sat = shr;
        word_o = mute_i ? '0 : WORD'(sat);
    end
endmodule

// File: rtl/pcm56_frame_sched.sv
// Per-LRCK-frame transfer engine: 2-deep sample FIFO, lane word formation and
// latch-enable / MSB-first serial sequencing to NCH PCM56 DACs.
module pcm56_frame_sched
    import pcm56_pkg::*;
#(
    parameter int unsigned BIT  = BIT_DEF,
    parameter int unsigned WORD = WORD_DEF,
    parameter int unsigned NCH  = NCH_DEF
) (
    input  logic             bck_i,
    input  logic             rst_i,
    input  logic             lrck_i,
    input  logic             smp_valid_i,
    output logic             smp_ready_o,
    input  logic [BIT-1:0]   l_data_i,
    input  logic [BIT-1:0]   r_data_i,
    input  logic [2*NCH-1:0] ch_sel_i,
    input  logic             mute_i,
    input  logic             status_clr_i,
    output logic [NCH-1:0]   le_o,
    output logic [NCH-1:0]   sdo_o,
    output logic             busy_o,
    output logic             underrun_o,
    output logic             resync_o
);
    localparam int unsigned CW = $clog2(WORD);

    state_e          state_q, state_d, st_eff;
    logic            lrck_r_q, lrck_rr_q, frame_start;
    logic [CW-1:0]   bit_cnt_q;
    logic            load, shift_en, push, pop, set_un, set_rs;
    logic            under_q, resync_q;

    logic [BIT-1:0]  fl_q [2];
    logic [BIT-1:0]  fr_q [2];
    logic            wp_q, rp_q;
    logic [1:0]      fcnt_q, fcnt_d;
    logic [BIT-1:0]  held_l_q, held_r_q, src_l, src_r;

    logic [WORD-1:0] word_c [NCH];
    logic [WORD-1:0] sh_q   [NCH];

    assign frame_start = lrck_rr_q & ~lrck_r_q;
    assign smp_ready_o = (fcnt_q != 2'd2);
    assign push        = smp_valid_i & smp_ready_o;
    assign pop         = load & (fcnt_q != 2'd0);
    assign fcnt_d      = fcnt_q + 2'(push) - 2'(pop);
    assign set_un      = load & (fcnt_q == 2'd0);
    assign set_rs      = frame_start & ((state_q == SHIFT) || (state_q == LATCH));

    // The word for this frame comes from the pair being popped, else the held one.
    assign src_l = pop ? fl_q[rp_q] : held_l_q;
    assign src_r = pop ? fr_q[rp_q] : held_r_q;

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        pcm56_word_fmt #(.BIT(BIT), .WORD(WORD)) u_fmt (
            .l_i    (src_l),
            .r_i    (src_r),
            .sel_i  (ch_sel_i[2*c +: 2]),
            .mute_i (mute_i),
            .word_o (word_c[c])
        );
    end

    // A frame start forces LOAD in the same cycle, aborting any transfer in flight.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        st_eff   = frame_start ? LOAD : state_q;
        case (st_eff)
            LOAD: begin
                load    = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt_q == CW'(WORD - 1)) state_d = LATCH;
            end
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (st_eff != IDLE);
        le_o   = {NCH{state_q != LATCH}};
        for (int c = 0; c < NCH; c++) begin
            sdo_o[c] = (state_q == SHIFT) & sh_q[c][WORD-1];
        end
    end

    assign underrun_o = under_q;
    assign resync_o   = resync_q;

    always_ff @(negedge bck_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            lrck_r_q  <= 1'b0;
            lrck_rr_q <= 1'b0;
            bit_cnt_q <= '0;
            under_q   <= 1'b0;
            resync_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            lrck_r_q  <= lrck_i;
            lrck_rr_q <= lrck_r_q;
            if (load)          bit_cnt_q <= '0;
            else if (shift_en) bit_cnt_q <= bit_cnt_q + CW'(1);
            under_q   <= set_un | (under_q & ~status_clr_i);
            resync_q  <= set_rs | (resync_q & ~status_clr_i);
        end
    end

    always_ff @(negedge bck_i) begin
        if (rst_i) begin
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            fcnt_q   <= 2'd0;
            held_l_q <= '0;
            held_r_q <= '0;
        end else begin
            if (push) begin
                fl_q[wp_q] <= l_data_i;
                fr_q[wp_q] <= r_data_i;
                wp_q       <= ~wp_q;
            end
            if (pop) begin
                held_l_q <= fl_q[rp_q];
                held_r_q <= fr_q[rp_q];
                rp_q     <= ~rp_q;
            end
            fcnt_q <= fcnt_d;
        end
    end

    always_ff @(negedge bck_i) begin
        for (int c = 0; c < NCH; c++) begin
            if (rst_i)         sh_q[c] <= '0;
            else if (load)     sh_q[c] <= word_c[c];
            else if (shift_en) sh_q[c] <= {sh_q[c][WORD-2:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_pcm56_frame_sched.sv
// Bench for pcm56_frame_sched: table of single-frame vectors plus hand-built
// underrun, backpressure, resync and mid-transfer reset sequences.
module tb_pcm56_frame_sched;
    localparam int unsigned BIT  = 24;
    localparam int unsigned WORD = 16;
    localparam int unsigned NCH  = 4;

    logic            bck, rst, lrck, valid, ready, mute, clr;
    logic [BIT-1:0]  ldat, rdat;
    logic [2*NCH-1:0] sel;
    logic [NCH-1:0]  le, sdo;
    logic            busy, underrun, resync;

    typedef struct packed {
        logic [23:0]      l;
        logic [23:0]      r;
        logic [7:0]       sel;
        logic             mute;
        logic [3:0][15:0] w;
    } vec_t;

    typedef struct packed {
        logic [3:0][15:0] w;
        int               run;
    } exp_t;

    vec_t tbl [6];
    exp_t sbq [$];
    int   nchk = 0;
    int   errs = 0;

    pcm56_frame_sched #(.BIT(BIT), .WORD(WORD), .NCH(NCH)) dut (
        .bck_i        (bck),
        .rst_i        (rst),
        .lrck_i       (lrck),
        .smp_valid_i  (valid),
        .smp_ready_o  (ready),
        .l_data_i     (ldat),
        .r_data_i     (rdat),
        .ch_sel_i     (sel),
        .mute_i       (mute),
        .status_clr_i (clr),
        .le_o         (le),
        .sdo_o        (sdo),
        .busy_o       (busy),
        .underrun_o   (underrun),
        .resync_o     (resync)
    );

    initial bck = 1'b0;
    always #5 bck = ~bck;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge bck);
        #1;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        chk("push_ready", ready, 1'b1);
        ldat  = l;
        rdat  = r;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic frame();
        lrck = 1'b0;
        tick();
        lrck = 1'b1;
        repeat (WORD + 3) tick();
    endtask

    task automatic expect_words(input logic [3:0][15:0] w, input int run);
        exp_t e;
        e.w   = w;
        e.run = run;
        sbq.push_back(e);
    endtask

    // Collects serial bits while le is high, compares at the latch cycle.
    logic [3:0][15:0] acc;
    int               run_cnt;
    always @(posedge bck) begin
        exp_t e;
        if (rst) begin
            acc     = '0;
            run_cnt = 0;
        end else if (busy && le == 4'hF) begin
            for (int c = 0; c < NCH; c++) acc[c] = {acc[c][14:0], sdo[c]};
            run_cnt++;
        end else if (busy && le == 4'h0) begin
            if (sbq.size() == 0) begin
                nchk++;
                errs++;
                $display("FAIL unexpected_latch: got words %h expected no transfer", acc);
            end else begin
                e = sbq.pop_front();
                chk("lane_words", acc, e.w);
                if (e.run != 0) chk("le_high_cycles", 64'(run_cnt), 64'(e.run));
                chk("latch_sdo", sdo, 4'h0);
            end
            acc     = '0;
            run_cnt = 0;
        end
    end

    initial begin
        tbl[0] = '{l:24'h1234C0, r:24'h000000, sel:8'h00, mute:1'b0, w:{16'h1235, 16'h1235, 16'h1235, 16'h1235}};
        tbl[1] = '{l:24'h7FFFF0, r:24'hC00000, sel:8'h78, mute:1'b0, w:{16'hC000, 16'h0000, 16'h2000, 16'h7FFF}};
        tbl[2] = '{l:24'h400000, r:24'hC00000, sel:8'hC8, mute:1'b0, w:{16'h0000, 16'h4000, 16'h0000, 16'h4000}};
        tbl[3] = '{l:24'h123456, r:24'h654321, sel:8'h00, mute:1'b1, w:{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
        tbl[4] = '{l:24'hFFFF80, r:24'hFFFF7F, sel:8'hD2, mute:1'b0, w:{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF}};
        tbl[5] = '{l:24'h800000, r:24'h7FFFFF, sel:8'h00, mute:1'b0, w:{16'h8000, 16'h8000, 16'h8000, 16'h8000}};

        rst = 1'b1; lrck = 1'b1; valid = 1'b0; mute = 1'b0; clr = 1'b0;
        ldat = '0; rdat = '0; sel = '0;
        tick(); tick();
        chk("rst_le", le, 4'hF);
        chk("rst_sdo", sdo, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", ready, 1'b1);
        chk("rst_flags", {underrun, resync}, 2'b00);
        rst = 1'b0;
        tick(); tick();

        for (int i = 0; i < 6; i++) begin
            push(tbl[i].l, tbl[i].r);
            sel  = tbl[i].sel;
            mute = tbl[i].mute;
            expect_words(tbl[i].w, WORD + 1);
            frame();
        end
        chk("no_underrun", underrun, 1'b0);

        // Empty buffer: held pair repeats and the sticky flag sets.
        expect_words(tbl[5].w, WORD + 1);
        frame();
        chk("underrun_set", underrun, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0; tick();
        chk("underrun_clr", underrun, 1'b0);

        // Two-deep buffer: third push refused until a frame pops.
        sel = 8'h00; mute = 1'b0;
        push(24'h0A0A00, 24'h0);
        push(24'h0B0B00, 24'h0);
        chk("bp_full", ready, 1'b0);
        ldat = 24'h0C0C00; valid = 1'b1; tick(); valid = 1'b0;
        expect_words({4{16'h0A0A}}, WORD + 1);
        frame();
        chk("bp_ready_back", ready, 1'b1);
        expect_words({4{16'h0B0B}}, WORD + 1);
        frame();
        chk("bp_no_underrun", underrun, 1'b0);
        expect_words({4{16'h0B0B}}, WORD + 1);
        frame();
        chk("bp_third_dropped", underrun, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0; tick();

        // Second LRCK fall lands during shift bit 5.
        push(24'h111100, 24'h0);
        push(24'h2222C0, 24'h0);
        expect_words({4{16'h2223}}, 0);
        lrck = 1'b0; tick(); lrck = 1'b1;
        repeat (5) tick();
        lrck = 1'b0; tick(); lrck = 1'b1;
        repeat (WORD + 3) tick();
        chk("resync_set", resync, 1'b1);
        chk("resync_no_underrun", underrun, 1'b0);
        clr = 1'b1; tick(); clr = 1'b0; tick();
        chk("resync_clr", resync, 1'b0);

        // Reset in the middle of a shift.
        push(24'h555500, 24'h0);
        lrck = 1'b0; tick(); lrck = 1'b1;
        repeat (5) tick();
        chk("midshift_busy", busy, 1'b1);
        rst = 1'b1; tick(); tick();
        chk("mrst_le", le, 4'hF);
        chk("mrst_sdo", sdo, 4'h0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ready", ready, 1'b1);
        chk("mrst_flags", {underrun, resync}, 2'b00);
        rst = 1'b0; tick(); tick();
        expect_words({4{16'h0000}}, WORD + 1);
        frame();
        chk("mrst_held_zero_underrun", underrun, 1'b1);

        for (int k = 0; k < 50 && sbq.size() != 0; k++) tick();
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
